// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Summary  : Byte FIFO that drains into a UART transmit controller through a
//            tx_byte / tx_trigger / tx_done handshake. Define
//            UART_TX_FIFO_OVF_CNT_EN to add a saturating dropped-write counter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [7:0]          wr_byte,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] level,
    output logic                busy,
    output logic [7:0]          tx_byte,
    output logic                tx_trigger,
    input  logic                tx_done
`ifdef UART_TX_FIFO_OVF_CNT_EN
    ,
    output logic [7:0]          ovf_cnt
`endif
);

    localparam int                  c_DEPTH   = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_TRIG = 2'd2;
    localparam logic [1:0] c_ST_WAIT = 2'd3;

    logic [7:0]          r_mem [c_DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic [1:0]          r_state;
    logic                r_busy;
    logic                r_tx_trigger;
    logic [7:0]          r_tx_byte;
    logic                w_full;
    logic                w_empty;
    logic                w_push;

    // Extra pointer bit separates the full and empty cases when low bits match.
    assign w_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = wr_en && !w_full;

    assign full       = w_full;
    assign empty      = w_empty;
    assign level      = r_wr_ptr - r_rd_ptr;
    assign busy       = r_busy;
    assign tx_byte    = r_tx_byte;
    assign tx_trigger = r_tx_trigger;

    always_ff @(posedge sclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= wr_byte;
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_rd_ptr     <= '0;
            r_busy       <= 1'b0;
            r_tx_trigger <= 1'b0;
            r_tx_byte    <= 8'hFF;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    r_tx_byte    <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
                    r_rd_ptr     <= r_rd_ptr + c_PTR_ONE;
                    r_busy       <= 1'b1;
                    r_tx_trigger <= 1'b1;
                    r_state      <= c_ST_TRIG;
                end
                c_ST_TRIG: begin
                    r_tx_trigger <= 1'b0;
                    r_state      <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // tx_done only matters here; pulses in other states are ignored.
                    if (tx_done) begin
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_ovf_cnt <= 8'h00;
        end else if (wr_en && w_full && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'h01;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

endmodule
`default_nettype wire
